// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory request/response port between an instruction-fetch
// requester (read only) and a load/store requester. Only one transaction is
// in flight at a time. Grants alternate round-robin when both sides request.
// A fetch redirect (if_flush) suppresses delivery of the outstanding fetch
// response, but the memory handshake is still completed.
//
// Ports
//   clk, rst                    clock, synchronous active-low reset
//   if_req_valid/ready/addr     fetch request handshake and address
//   if_flush                    fetch redirect, drops an outstanding fetch response
//   ls_req_valid/ready          load/store request handshake
//   ls_req_addr/we/wdata/wstrb  load/store request payload
//   mem_req_valid/ready         shared memory request handshake
//   mem_req_addr/we/wdata/wstrb memory request payload (registered)
//   mem_resp_valid/data         memory response, one per accepted request
//   if_resp_valid/data          fetch response (one-cycle pulse, data held)
//   ls_resp_valid/data          load data or write acknowledge (pulse, data held)
//   busy                        high while a transaction is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter type T = logic [31:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req_valid,
    output logic       if_req_ready,
    input  T           if_req_addr,
    input  logic       if_flush,
    input  logic       ls_req_valid,
    output logic       ls_req_ready,
    input  T           ls_req_addr,
    input  logic       ls_req_we,
    input  T           ls_req_wdata,
    input  logic [3:0] ls_req_wstrb,
    output logic       mem_req_valid,
    input  logic       mem_req_ready,
    output T           mem_req_addr,
    output logic       mem_req_we,
    output T           mem_req_wdata,
    output logic [3:0] mem_req_wstrb,
    input  logic       mem_resp_valid,
    input  T           mem_resp_data,
    output logic       if_resp_valid,
    output T           if_resp_data,
    output logic       ls_resp_valid,
    output T           ls_resp_data,
    output logic       busy
);

    localparam T WORD_ZERO = T'(32'd0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e     state_q,    state_d;
    logic       owner_ls_q, owner_ls_d;   // 1: current transaction belongs to load/store
    logic       last_ls_q,  last_ls_d;    // 1: load/store received the most recent grant
    logic       drop_q,     drop_d;       // fetch response must be swallowed
    T           addr_q,     addr_d;
    logic       we_q,       we_d;
    T           wdata_q,    wdata_d;
    logic [3:0] wstrb_q,    wstrb_d;
    logic       if_rv_q,    if_rv_d;
    logic       ls_rv_q,    ls_rv_d;
    T           if_rd_q,    if_rd_d;
    T           ls_rd_q,    ls_rd_d;

    logic       grant_ls_s;
    logic       flush_hit_s;

    // Next-state, grant and response-routing logic
    always_comb begin
        state_d      = state_q;
        owner_ls_d   = owner_ls_q;
        last_ls_d    = last_ls_q;
        drop_d       = drop_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        if_rv_d      = 1'b0;
        ls_rv_d      = 1'b0;
        if_rd_d      = if_rd_q;
        ls_rd_d      = ls_rd_q;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;

        // Load/store wins when it is alone, or when both request and fetch
        // was not the loser of the previous contest (i.e. fetch went last).
        grant_ls_s  = ls_req_valid && (!if_req_valid || !last_ls_q);
        flush_hit_s = if_flush && !owner_ls_q;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                // No grant is issued during a reset cycle; it would be discarded.
                if (rst && (if_req_valid || ls_req_valid)) begin
                    state_d    = ST_REQ;
                    owner_ls_d = grant_ls_s;
                    last_ls_d  = grant_ls_s;
                    if (grant_ls_s) begin
                        ls_req_ready = 1'b1;
                        addr_d       = ls_req_addr;
                        we_d         = ls_req_we;
                        wdata_d      = ls_req_wdata;
                        wstrb_d      = ls_req_wstrb;
                    end else begin
                        if_req_ready = 1'b1;
                        addr_d       = if_req_addr;
                        we_d         = 1'b0;
                        wdata_d      = WORD_ZERO;
                        wstrb_d      = 4'b0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (flush_hit_s) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    if (owner_ls_q) begin
                        ls_rv_d = 1'b1;
                        ls_rd_d = mem_resp_data;
                    end else if (!(drop_q || if_flush)) begin
                        // A flush arriving with the response still cancels it.
                        if_rv_d = 1'b1;
                        if_rd_d = mem_resp_data;
                    end else begin
                        if_rv_d = 1'b0;
                    end
                end else begin
                    state_d = ST_WAIT;
                    if (flush_hit_s) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and payload registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_ls_q <= 1'b0;
            last_ls_q  <= 1'b1;   // fetch wins the first contest after reset
            drop_q     <= 1'b0;
            addr_q     <= WORD_ZERO;
            we_q       <= 1'b0;
            wdata_q    <= WORD_ZERO;
            wstrb_q    <= 4'b0000;
            if_rv_q    <= 1'b0;
            ls_rv_q    <= 1'b0;
            if_rd_q    <= WORD_ZERO;
            ls_rd_q    <= WORD_ZERO;
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            last_ls_q  <= last_ls_d;
            drop_q     <= drop_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            if_rv_q    <= if_rv_d;
            ls_rv_q    <= ls_rv_d;
            if_rd_q    <= if_rd_d;
            ls_rd_q    <= ls_rd_d;
        end
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign if_resp_valid = if_rv_q;
    assign if_resp_data  = if_rd_q;
    assign ls_resp_valid = ls_rv_q;
    assign ls_resp_data  = ls_rd_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    typedef logic [31:0] word_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_req_valid, if_req_ready, if_flush;
    word_t      if_req_addr;
    logic       ls_req_valid, ls_req_ready, ls_req_we;
    word_t      ls_req_addr, ls_req_wdata;
    logic [3:0] ls_req_wstrb;
    logic       mem_req_valid, mem_req_ready, mem_req_we;
    word_t      mem_req_addr, mem_req_wdata;
    logic [3:0] mem_req_wstrb;
    logic       mem_resp_valid;
    word_t      mem_resp_data;
    logic       if_resp_valid, ls_resp_valid, busy;
    word_t      if_resp_data, ls_resp_data;

    int errors = 0;
    int checks = 0;

    // Last value delivered to each requester, tracked by the bench
    word_t held_if, held_ls;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_addr    (if_req_addr),
        .if_flush       (if_flush),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_req_addr    (ls_req_addr),
        .ls_req_we      (ls_req_we),
        .ls_req_wdata   (ls_req_wdata),
        .ls_req_wstrb   (ls_req_wstrb),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .ls_resp_valid  (ls_resp_valid),
        .ls_resp_data   (ls_resp_data),
        .busy           (busy)
    );

    // ctl vector: {if_req_ready, ls_req_ready, mem_req_valid, busy, if_resp_valid, ls_resp_valid}
    function automatic logic [5:0] ctl();
        return {if_req_ready, ls_req_ready, mem_req_valid, busy, if_resp_valid, ls_resp_valid};
    endfunction

    function automatic logic [68:0] payload();
        return {mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        if_req_valid   = 1'b0;
        if_req_addr    = 32'h0;
        if_flush       = 1'b0;
        ls_req_valid   = 1'b0;
        ls_req_addr    = 32'h0;
        ls_req_we      = 1'b0;
        ls_req_wdata   = 32'h0;
        ls_req_wstrb   = 4'b0000;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
    endtask

    // Leaves the bench just after a falling edge with reset released
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", 128'(ctl()), 128'(6'b000000));
        check("reset_payload", 128'(payload()), 128'(69'd0));
        check("reset_rdata", 128'({if_resp_data, ls_resp_data}), 128'(64'd0));
        held_if = 32'h0;
        held_ls = 32'h0;
        rst = 1'b1;
    endtask

    typedef struct {
        logic  ifv;
        logic  lsv;
        logic  we;
        word_t addr;
        word_t rdata;
        logic  exp_ls;
    } vec_t;

    // One full zero-latency transaction, starting just after a falling edge in IDLE
    task automatic run_vec(input vec_t v, input string tag);
        word_t      e_addr, e_wdata;
        logic       e_we;
        logic [3:0] e_wstrb;
        if_req_valid = v.ifv;
        if_req_addr  = v.addr;
        ls_req_valid = v.lsv;
        ls_req_addr  = v.addr ^ 32'h0000_1000;
        ls_req_we    = v.we;
        ls_req_wdata = ~v.addr;
        ls_req_wstrb = 4'b0101;
        #1;
        check({tag, "_grant"}, 128'({if_req_ready, ls_req_ready}), 128'({~v.exp_ls, v.exp_ls}));
        e_addr  = v.exp_ls ? (v.addr ^ 32'h0000_1000) : v.addr;
        e_we    = v.exp_ls ? v.we : 1'b0;
        e_wdata = v.exp_ls ? ~v.addr : 32'h0;
        e_wstrb = v.exp_ls ? 4'b0101 : 4'b0000;
        @(negedge clk);
        if_req_valid  = 1'b0;
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check({tag, "_req"}, 128'(ctl()), 128'(6'b001100));
        check({tag, "_payload"}, 128'(payload()), 128'({e_addr, e_we, e_wdata, e_wstrb}));
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.rdata;
        #1;
        check({tag, "_wait"}, 128'(ctl()), 128'(6'b000100));
        @(negedge clk);
        mem_resp_valid = 1'b0;
        if (v.exp_ls) held_ls = v.rdata;
        else          held_if = v.rdata;
        #1;
        check({tag, "_resp"}, 128'(ctl()), 128'({4'b0000, ~v.exp_ls, v.exp_ls}));
        check({tag, "_rdata"}, 128'({if_resp_data, ls_resp_data}), 128'({held_if, held_ls}));
    endtask

    // Behavioural reference model state (transaction level)
    int         m_phase;      // 0 idle, 1 request issued, 2 awaiting response
    logic       m_owner_ls, m_last_ls, m_drop, m_if_pulse, m_ls_pulse;
    word_t      m_addr, m_wdata, m_if_rd, m_ls_rd;
    logic       m_we;
    logic [3:0] m_wstrb;

    task automatic model_reset();
        m_phase = 0; m_owner_ls = 1'b0; m_last_ls = 1'b1; m_drop = 1'b0;
        m_if_pulse = 1'b0; m_ls_pulse = 1'b0;
        m_addr = 32'h0; m_wdata = 32'h0; m_we = 1'b0; m_wstrb = 4'b0000;
        m_if_rd = 32'h0; m_ls_rd = 32'h0;
    endtask

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        held_if = 32'h0;
        held_ls = 32'h0;

        // Round-robin table after reset: pointer starts favouring fetch
        vecs[0] = '{ifv:1'b1, lsv:1'b0, we:1'b0, addr:32'h0000_0100, rdata:32'h1111_0001, exp_ls:1'b0};
        vecs[1] = '{ifv:1'b1, lsv:1'b1, we:1'b1, addr:32'h0000_0204, rdata:32'h2222_0002, exp_ls:1'b1};
        vecs[2] = '{ifv:1'b1, lsv:1'b1, we:1'b0, addr:32'h0000_0308, rdata:32'h3333_0003, exp_ls:1'b0};
        vecs[3] = '{ifv:1'b0, lsv:1'b1, we:1'b0, addr:32'h0000_040C, rdata:32'h4444_0004, exp_ls:1'b1};
        vecs[4] = '{ifv:1'b0, lsv:1'b1, we:1'b1, addr:32'h0000_0510, rdata:32'h5555_0005, exp_ls:1'b1};
        vecs[5] = '{ifv:1'b1, lsv:1'b1, we:1'b1, addr:32'h0000_0614, rdata:32'h6666_0006, exp_ls:1'b0};
        vecs[6] = '{ifv:1'b1, lsv:1'b0, we:1'b0, addr:32'h0000_0718, rdata:32'h7777_0007, exp_ls:1'b0};
        vecs[7] = '{ifv:1'b1, lsv:1'b1, we:1'b0, addr:32'h0000_081C, rdata:32'h8888_0008, exp_ls:1'b1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Fetch with 0x40, response two cycles after acceptance
        @(negedge clk);
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0040; mem_req_ready = 1'b1;
        #1; check("f_grant", 128'(ctl()), 128'(6'b100000));
        @(negedge clk);
        if_req_valid = 1'b0;
        #1; check("f_req", 128'(ctl()), 128'(6'b001100));
        check("f_payload", 128'(payload()), 128'({32'h0000_0040, 1'b0, 32'h0, 4'b0000}));
        @(negedge clk);
        #1; check("f_wait1", 128'(ctl()), 128'(6'b000100));
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0093;
        #1; check("f_wait2", 128'(ctl()), 128'(6'b000100));
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0; held_if = 32'h0010_0093;
        #1; check("f_resp", 128'(ctl()), 128'(6'b000010));
        check("f_rdata", 128'({if_resp_data, ls_resp_data}), 128'({held_if, held_ls}));
        @(negedge clk);
        #1; check("f_after", 128'(ctl()), 128'(6'b000000));
        check("f_hold", 128'(if_resp_data), 128'(32'h0010_0093));

        // Store held off by memory for three cycles
        @(negedge clk);
        ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h0000_0100;
        ls_req_wdata = 32'hDEAD_BEEF; ls_req_wstrb = 4'b1111;
        #1; check("st_grant", 128'(ctl()), 128'(6'b010000));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ls_req_valid = 1'b0;
            ls_req_addr = $urandom; ls_req_wdata = $urandom; ls_req_wstrb = 4'($urandom);
            ls_req_we = 1'($urandom_range(1));
            mem_req_ready = (k == 3);
            #1; check($sformatf("st_req%0d", k), 128'(ctl()), 128'(6'b001100));
            check($sformatf("st_payload%0d", k), 128'(payload()),
                  128'({32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'b1111}));
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0001;
        #1; check("st_wait", 128'(ctl()), 128'(6'b000100));
        @(negedge clk);
        mem_resp_valid = 1'b0; held_ls = 32'h0000_0001;
        #1; check("st_resp", 128'(ctl()), 128'(6'b000001));
        check("st_rdata", 128'({if_resp_data, ls_resp_data}), 128'({held_if, held_ls}));
        @(negedge clk);
        #1; check("st_after", 128'(ctl()), 128'(6'b000000));

        // Fetch flushed while waiting for its response
        @(negedge clk);
        idle_inputs();
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0200;
        #1; check("fl_grant", 128'(ctl()), 128'(6'b100000));
        @(negedge clk);
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1; check("fl_req", 128'(ctl()), 128'(6'b001100));
        @(negedge clk);
        mem_req_ready = 1'b0; if_flush = 1'b1;
        #1; check("fl_wait", 128'(ctl()), 128'(6'b000100));
        @(negedge clk);
        if_flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
        #1; check("fl_resp_in", 128'(ctl()), 128'(6'b000100));
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1; check("fl_dropped", 128'(ctl()), 128'(6'b000000));
        check("fl_rdata", 128'({if_resp_data, ls_resp_data}), 128'({held_if, held_ls}));
        run_vec('{ifv:1'b1, lsv:1'b1, we:1'b0, addr:32'h0000_0900, rdata:32'h9999_0009, exp_ls:1'b1}, "fl_next");

        // Reset in WAIT of a fetch, stale response afterwards
        @(negedge clk);
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0A00;
        #1; check("rs_grant", 128'(ctl()), 128'(6'b100000));
        @(negedge clk);
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1; check("rs_req", 128'(ctl()), 128'(6'b001100));
        @(negedge clk);
        mem_req_ready = 1'b0; rst = 1'b0;
        #1; check("rs_wait", 128'(ctl()), 128'(6'b000100));
        @(negedge clk);
        rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0BAD;
        held_if = 32'h0; held_ls = 32'h0;
        #1; check("rs_after", 128'(ctl()), 128'(6'b000000));
        check("rs_payload", 128'(payload()), 128'(69'd0));
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1; check("rs_stale", 128'(ctl()), 128'(6'b000000));
        check("rs_rdata", 128'({if_resp_data, ls_resp_data}), 128'(64'd0));
        run_vec('{ifv:1'b1, lsv:1'b1, we:1'b0, addr:32'h0000_0C00, rdata:32'hCCCC_000C, exp_ls:1'b0}, "rs_next");

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic       gnt, pick_ls, e_ifr, e_lsr;
            logic [5:0] e_ctl;
            @(negedge clk);
            rst           = ($urandom_range(99) != 0);
            if_req_valid  = 1'($urandom_range(1));
            if_req_addr   = $urandom;
            ls_req_valid  = 1'($urandom_range(1));
            ls_req_addr   = $urandom;
            ls_req_we     = 1'($urandom_range(1));
            ls_req_wdata  = $urandom;
            ls_req_wstrb  = 4'($urandom);
            if_flush      = ($urandom_range(5) == 0);
            mem_req_ready = ($urandom_range(9) < 6);
            if (m_phase == 2) mem_resp_valid = ($urandom_range(9) < 4);
            else              mem_resp_valid = ($urandom_range(9) == 0);
            mem_resp_data = $urandom;
            #1;
            gnt     = rst && (m_phase == 0) && (if_req_valid || ls_req_valid);
            pick_ls = ls_req_valid && (!if_req_valid || !m_last_ls);
            e_ifr   = gnt && !pick_ls;
            e_lsr   = gnt && pick_ls;
            e_ctl   = {e_ifr, e_lsr, (m_phase == 1), (m_phase != 0), m_if_pulse, m_ls_pulse};
            check("rnd_ctl", 128'(ctl()), 128'(e_ctl));
            check("rnd_payload", 128'(payload()), 128'({m_addr, m_we, m_wdata, m_wstrb}));
            check("rnd_rdata", 128'({if_resp_data, ls_resp_data}), 128'({m_if_rd, m_ls_rd}));
            // Advance model to the state after the coming rising edge
            m_if_pulse = 1'b0;
            m_ls_pulse = 1'b0;
            if (!rst) begin
                model_reset();
            end else if (m_phase == 0) begin
                m_drop = 1'b0;
                if (gnt) begin
                    m_phase    = 1;
                    m_owner_ls = pick_ls;
                    m_last_ls  = pick_ls;
                    m_addr     = pick_ls ? ls_req_addr : if_req_addr;
                    m_we       = pick_ls ? ls_req_we : 1'b0;
                    m_wdata    = pick_ls ? ls_req_wdata : 32'h0;
                    m_wstrb    = pick_ls ? ls_req_wstrb : 4'b0000;
                end
            end else if (m_phase == 1) begin
                if (if_flush && !m_owner_ls) m_drop = 1'b1;
                if (mem_req_ready) m_phase = 2;
            end else begin
                if (mem_resp_valid) begin
                    if (m_owner_ls) begin
                        m_ls_pulse = 1'b1;
                        m_ls_rd    = mem_resp_data;
                    end else if (!m_drop && !if_flush) begin
                        m_if_pulse = 1'b1;
                        m_if_rd    = mem_resp_data;
                    end
                    m_phase = 0;
                    m_drop  = 1'b0;
                end else if (if_flush && !m_owner_ls) begin
                    m_drop = 1'b1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
